// File: rtl/mem_lsu_port.sv
// Load/store initiator between the MEM stage and the async-read byte memory.
// Define MEM_LSU_MISALIGN_CHECK_EN to flag misaligned accesses instead of force-aligning them.
module mem_lsu_port #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [ADDR_WIDTH-1:0]   dw_addr,
  output logic [DATA_WIDTH-1:0]   dw_data,
  output logic [(DATA_WIDTH>>3)-1:0] dw_mask,
  output logic                    dw_en
);
  localparam int MASK_WIDTH = DATA_WIDTH >> 3;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [2:0]            op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  err;
  } req_t;

  state_t state, state_nxt;
  req_t   lat;

  logic                  is_half, is_word, acc_err;
  logic [ADDR_WIDTH-1:0] acc_addr;

  always_comb begin
    is_half  = (req_op == 3'd2) || (req_op == 3'd3) || (req_op == 3'd6);
    is_word  = (req_op == 3'd4) || (req_op == 3'd7);
    acc_addr = req_addr;
    acc_err  = 1'b0;
`ifdef MEM_LSU_MISALIGN_CHECK_EN
    acc_err  = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
    // Without the check, drop the offending low bits so the access stays aligned.
    if (is_half) acc_addr[0]   = 1'b0;
    if (is_word) acc_addr[1:0] = 2'b00;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)  state_nxt = ACCESS;
      ACCESS:                  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  logic                  is_store;
  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] shifted, load_ext;

  assign is_store = lat.op[2] & (lat.op[1] | lat.op[0]);
  assign off      = lat.addr[1:0];
  assign shifted  = mem_rdata >> {off, 3'b000};

  always_comb begin
    case (lat.op)
      3'd0:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_ext = {24'd0, shifted[7:0]};
      3'd2:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'd3:    load_ext = {16'd0, shifted[15:0]};
      3'd4:    load_ext = mem_rdata;
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat        <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid)
        lat <= '{op: req_op, addr: acc_addr, wdata: req_wdata, err: acc_err};
      if (state == ACCESS) begin
        resp_rdata <= (is_store || lat.err) ? '0 : load_ext;
        resp_err   <= lat.err;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_addr   = {lat.addr[ADDR_WIDTH-1:2], 2'b00};
  assign dw_addr    = {lat.addr[ADDR_WIDTH-1:2], 2'b00};

  // Reset gates the strobe so a store caught mid-ACCESS never commits.
  assign dw_en = (state == ACCESS) && is_store && !lat.err && !reset;

  always_comb begin
    dw_mask = '0;
    if (dw_en) begin
      case (lat.op)
        3'd5:    dw_mask = MASK_WIDTH'(4'b0001 << off);
        3'd6:    dw_mask = MASK_WIDTH'(4'b0011 << off);
        default: dw_mask = '1;
      endcase
    end
  end

  logic [MASK_WIDTH-1:0][7:0] lane_data;

  for (genvar i = 0; i < MASK_WIDTH; i++) begin : g_lane
    assign lane_data[i] = (lat.op == 3'd5) ? lat.wdata[7:0] :
                          (lat.op == 3'd6) ? lat.wdata[8*(i%2) +: 8] :
                                             lat.wdata[8*i +: 8];
  end

  assign dw_data = lane_data;
endmodule

// File: tb/tb_mem_lsu_port.sv
// Directed bench for mem_lsu_port with a small word-array memory behind the ports.
module tb_mem_lsu_port;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr, dw_addr;
  logic [31:0]   mem_rdata, dw_data;
  logic [3:0]    dw_mask;
  logic          dw_en;

  int checks = 0;
  int errors = 0;

  mem_lsu_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dw_addr(dw_addr), .dw_data(dw_data), .dw_mask(dw_mask), .dw_en(dw_en)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (dw_en)
      for (int b = 0; b < 4; b++)
        if (dw_mask[b]) mem[dw_addr[9:2]][8*b +: 8] <= dw_data[8*b +: 8];

  // Values captured in ACCESS (a_*) and RESP (r_*) by the issue task
  logic          a_en, a_rvalid, a_rready, r_en, r_valid, r_err;
  logic [3:0]    a_mask;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_data, r_rdata;

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    a_en = dw_en; a_mask = dw_mask; a_addr = dw_addr; a_data = dw_data;
    a_rvalid = resp_valid; a_rready = req_ready;
    @(negedge clk);
    r_en = dw_en; r_valid = resp_valid; r_rdata = resp_rdata; r_err = resp_err;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1)   begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0)  begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    checks++; if (dw_en !== 1'b0)       begin errors++; $display("FAIL reset_dw_en got %b exp 0", dw_en); end
    checks++; if (dw_mask !== 4'h0)     begin errors++; $display("FAIL reset_dw_mask got %h exp 0", dw_mask); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
    checks++; if (mem_addr !== '0)      begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    reset = 1'b0;
  endtask

  task automatic test_word;
    issue(3'd7, 21'h100, 32'hDEADBEEF);
    checks++; if (a_en !== 1'b1)      begin errors++; $display("FAIL sw_dw_en got %b exp 1", a_en); end
    checks++; if (a_mask !== 4'hF)    begin errors++; $display("FAIL sw_mask got %h exp f", a_mask); end
    checks++; if (a_addr !== 21'h100) begin errors++; $display("FAIL sw_addr got %h exp 100", a_addr); end
    checks++; if (a_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data got %h exp deadbeef", a_data); end
    checks++; if (a_rready !== 1'b0)  begin errors++; $display("FAIL sw_ready_access got %b exp 0", a_rready); end
    checks++; if (r_en !== 1'b0)      begin errors++; $display("FAIL sw_en_one_cycle got %b exp 0", r_en); end
    checks++; if (r_rdata !== 32'h0)  begin errors++; $display("FAIL sw_resp_rdata got %h exp 0", r_rdata); end
    issue(3'd4, 21'h100, 32'h0);
    checks++; if (a_rvalid !== 1'b0)  begin errors++; $display("FAIL lw_early_valid got %b exp 0", a_rvalid); end
    checks++; if (a_en !== 1'b0)      begin errors++; $display("FAIL lw_dw_en got %b exp 0", a_en); end
    checks++; if (r_valid !== 1'b1)   begin errors++; $display("FAIL lw_resp_valid got %b exp 1", r_valid); end
    checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", r_rdata); end
  endtask

  task automatic test_byte;
    issue(3'd5, 21'h103, 32'h00000080);
    checks++; if (a_mask !== 4'b1000)      begin errors++; $display("FAIL sb_mask got %b exp 1000", a_mask); end
    checks++; if (a_data !== 32'h80808080) begin errors++; $display("FAIL sb_data got %h exp 80808080", a_data); end
    checks++; if (a_addr !== 21'h100)      begin errors++; $display("FAIL sb_addr got %h exp 100", a_addr); end
    issue(3'd0, 21'h103, 32'h0);
    checks++; if (r_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h exp ffffff80", r_rdata); end
    issue(3'd1, 21'h103, 32'h0);
    checks++; if (r_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got %h exp 00000080", r_rdata); end
    issue(3'd1, 21'h101, 32'h0);
    checks++; if (r_rdata !== 32'h000000BE) begin errors++; $display("FAIL lbu1_rdata got %h exp 000000be", r_rdata); end
    issue(3'd4, 21'h100, 32'h0);
    checks++; if (r_rdata !== 32'h80ADBEEF) begin errors++; $display("FAIL sb_word got %h exp 80adbeef", r_rdata); end
  endtask

  task automatic test_half;
    issue(3'd6, 21'h102, 32'h00008001);
    checks++; if (a_mask !== 4'b1100)      begin errors++; $display("FAIL sh_mask got %b exp 1100", a_mask); end
    checks++; if (a_data !== 32'h80018001) begin errors++; $display("FAIL sh_data got %h exp 80018001", a_data); end
    issue(3'd2, 21'h102, 32'h0);
    checks++; if (r_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata got %h exp ffff8001", r_rdata); end
    issue(3'd3, 21'h102, 32'h0);
    checks++; if (r_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_rdata got %h exp 00008001", r_rdata); end
    issue(3'd2, 21'h100, 32'h0);
    checks++; if (r_rdata !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh0_rdata got %h exp ffffbeef", r_rdata); end
    issue(3'd4, 21'h100, 32'h0);
    checks++; if (r_rdata !== 32'h8001BEEF) begin errors++; $display("FAIL sh_word got %h exp 8001beef", r_rdata); end
  endtask

  task automatic test_backpressure;
    logic [31:0] first;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_addr = 21'h100; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    first = resp_rdata;
    checks++; if (first !== 32'h8001BEEF) begin errors++; $display("FAIL bp_rdata got %h exp 8001beef", first); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== 32'h8001BEEF) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b ready=%b rdata=%h exp 1 0 8001beef", i, resp_valid, req_ready, resp_rdata);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got ready=%b valid=%b exp 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_misalign;
    issue(3'd7, 21'h101, 32'h12345678);
`ifdef MEM_LSU_MISALIGN_CHECK_EN
    checks++; if (a_en !== 1'b0)     begin errors++; $display("FAIL mis_dw_en got %b exp 0", a_en); end
    checks++; if (a_mask !== 4'h0)   begin errors++; $display("FAIL mis_mask got %h exp 0", a_mask); end
    checks++; if (r_err !== 1'b1)    begin errors++; $display("FAIL mis_err got %b exp 1", r_err); end
    checks++; if (r_valid !== 1'b1)  begin errors++; $display("FAIL mis_valid got %b exp 1", r_valid); end
    issue(3'd4, 21'h100, 32'h0);
    checks++; if (r_rdata !== 32'h8001BEEF) begin errors++; $display("FAIL mis_nowrite got %h exp 8001beef", r_rdata); end
    checks++; if (r_err !== 1'b0)    begin errors++; $display("FAIL mis_err_clear got %b exp 0", r_err); end
    issue(3'd2, 21'h101, 32'h0);
    checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL mis_lh got err=%b rdata=%h exp 1 0", r_err, r_rdata); end
`else
    checks++; if (a_en !== 1'b1)      begin errors++; $display("FAIL mis_dw_en got %b exp 1", a_en); end
    checks++; if (a_mask !== 4'hF)    begin errors++; $display("FAIL mis_mask got %h exp f", a_mask); end
    checks++; if (a_addr !== 21'h100) begin errors++; $display("FAIL mis_addr got %h exp 100", a_addr); end
    checks++; if (r_err !== 1'b0)     begin errors++; $display("FAIL mis_err got %b exp 0", r_err); end
    issue(3'd3, 21'h101, 32'h0);
    checks++; if (r_rdata !== 32'h00005678) begin errors++; $display("FAIL mis_lhu got %h exp 00005678", r_rdata); end
`endif
  endtask

  task automatic test_reset_in_access;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd7; req_addr = 21'h104; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (dw_en !== 1'b0) begin errors++; $display("FAIL rst_access_dw_en got %b exp 0", dw_en); end
    @(negedge clk);
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_access_idle got ready=%b valid=%b exp 1 0", req_ready, resp_valid);
    end
    issue(3'd4, 21'h104, 32'h0);
    checks++; if (r_rdata !== 32'h0) begin errors++; $display("FAIL rst_access_nowrite got %h exp 0", r_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_backpressure;
    test_misalign;
    test_reset_in_access;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
